// File: rtl/word_serial_arbiter.sv
// word_serial_arbiter
//   Four-way round-robin arbiter that feeds a byte-serial serializer. Each
//   granted 32-bit word is held on Data_out with valid_out high for four
//   byte-rate cycles. GAP optional idle cycles follow before the next word.
//
// Ports
//   clk_4f     in   1   byte-rate clock, rising-edge active
//   reset      in   1   asynchronous, active-low reset
//   req        in   4   per-requester request
//   data_0..3  in  32   word offered by each requester
//   ack        out  4   one-hot, one-cycle capture pulse
//   valid_out  out  1   serializer valid, high for 4 cycles per word
//   Data_out   out 32   word being serialized; 0 when not valid
//   grant_id   out  2   index of the requester currently on Data_out
//   busy       out  1   high while in SEND or GAP
module word_serial_arbiter #(
  parameter int unsigned GAP = 0
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] data_0,
  input  logic [31:0] data_1,
  input  logic [31:0] data_2,
  input  logic [31:0] data_3,
  output logic [3:0]  ack,
  output logic        valid_out,
  output logic [31:0] Data_out,
  output logic [1:0]  grant_id,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Count value held during the final GAP cycle.
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [3:0]  gap_q, gap_d;
  logic [1:0]  rr_q, rr_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic [1:0]  grant_q, grant_d;
  logic [3:0]  ack_q, ack_d;

  logic        accept;
  logic [1:0]  winner;
  logic [31:0] win_data;

  // First set request bit, searching circularly upward from ptr.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign winner = rr_pick(req, rr_q);

  always_comb begin
    win_data = data_0;
    case (winner)
      2'd0: win_data = data_0;
      2'd1: win_data = data_1;
      2'd2: win_data = data_2;
      2'd3: win_data = data_3;
      default: win_data = data_0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    rr_d    = rr_q;
    data_d  = data_q;
    valid_d = valid_q;
    grant_d = grant_q;
    ack_d   = 4'b0000;
    accept  = 1'b0;

    case (state_q)
      ST_IDLE: accept = 1'b1;
      ST_SEND: begin
        if (beat_q != 2'd3) begin
          beat_d = beat_q + 2'd1;
        end else if (GAP == 0) begin
          accept = 1'b1;
        end else begin
          state_d = ST_GAP;
          valid_d = 1'b0;
          data_d  = '0;
          gap_d   = 4'd0;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) accept = 1'b1;
        else                   gap_d  = gap_q + 4'd1;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        data_d  = '0;
      end
    endcase

    // Requests are only looked at here; anything seen mid-word is ignored.
    if (accept) begin
      if (req != 4'b0000) begin
        state_d = ST_SEND;
        data_d  = win_data;
        valid_d = 1'b1;
        grant_d = winner;
        ack_d   = 4'b0001 << winner;
        beat_d  = 2'd0;
        rr_d    = winner + 2'd1;
      end else begin
        // grant_id keeps the last winner so it does not glitch while idle.
        state_d = ST_IDLE;
        valid_d = 1'b0;
        data_d  = '0;
        beat_d  = 2'd0;
      end
    end
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      beat_q  <= 2'd0;
      gap_q   <= 4'd0;
      rr_q    <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= 2'd0;
      ack_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
    end
  end

  assign ack       = ack_q;
  assign valid_out = valid_q;
  assign Data_out  = data_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_word_serial_arbiter.sv
module tb_word_serial_arbiter;

  logic        clk_4f = 1'b0;
  logic        reset  = 1'b0;
  logic [3:0]  req    = 4'b0000;
  logic [31:0] data_0 = '0;
  logic [31:0] data_1 = '0;
  logic [31:0] data_2 = '0;
  logic [31:0] data_3 = '0;

  logic [3:0]  ack;
  logic        valid_out;
  logic [31:0] Data_out;
  logic [1:0]  grant_id;
  logic        busy;

  logic [3:0]  ack_g;
  logic        valid_g;
  logic [31:0] data_g;
  logic [1:0]  grant_g;
  logic        busy_g;

  int checks = 0;
  int errors = 0;

  always #5 clk_4f = ~clk_4f;

  word_serial_arbiter #(.GAP(0)) dut (
    .clk_4f(clk_4f), .reset(reset), .req(req),
    .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .ack(ack), .valid_out(valid_out), .Data_out(Data_out),
    .grant_id(grant_id), .busy(busy)
  );

  word_serial_arbiter #(.GAP(2)) dut_g2 (
    .clk_4f(clk_4f), .reset(reset), .req(req),
    .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .ack(ack_g), .valid_out(valid_g), .Data_out(data_g),
    .grant_id(grant_g), .busy(busy_g)
  );

  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = 4'b1111;
    tick(); tick();
    checks++;
    if (valid_out !== 1'b0 || Data_out !== 32'h0 || ack !== 4'b0 || grant_id !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h ack=%b grant=%0d busy=%b, required 0/0/0/0/0",
               valid_out, Data_out, ack, grant_id, busy);
    end
    req = 4'b0000;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0001;
    data_0 = 32'hAABBCCDD;
    tick();
    checks++;
    if (ack !== 4'b0001 || valid_out !== 1'b1 || Data_out !== 32'hAABBCCDD || grant_id !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_start: ack=%b valid=%b data=%h grant=%0d busy=%b, required 0001/1/aabbccdd/0/1",
               ack, valid_out, Data_out, grant_id, busy);
    end
    req = 4'b0000;
    for (int b = 1; b < 4; b++) begin
      tick();
      checks++;
      if (ack !== 4'b0000 || valid_out !== 1'b1 || Data_out !== 32'hAABBCCDD) begin
        errors++;
        $display("FAIL single_beat%0d: ack=%b valid=%b data=%h, required 0000/1/aabbccdd",
                 b, ack, valid_out, Data_out);
      end
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || Data_out !== 32'h0 || busy !== 1'b0 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle: valid=%b data=%h busy=%b ack=%b, required 0/0/0/0000",
               valid_out, Data_out, busy, ack);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    pulse_reset();
    data_0 = 32'h00000000; data_1 = 32'h11111111;
    data_2 = 32'h22222222; data_3 = 32'h33333333;
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_g = 2'((k / 4) % 4);
      checks++;
      if (valid_out !== 1'b1) begin
        errors++;
        $display("FAIL rr_valid cycle %0d: valid=%b, required 1", k, valid_out);
      end
      if (k % 4 == 0) begin
        checks++;
        if (ack !== (4'b0001 << exp_g) || grant_id !== exp_g || Data_out !== {8{2'b00, exp_g}}) begin
          errors++;
          $display("FAIL rr_grant cycle %0d: ack=%b grant=%0d data=%h, required grant %0d",
                   k, ack, grant_id, Data_out, exp_g);
        end
      end else begin
        checks++;
        if (ack !== 4'b0000) begin
          errors++;
          $display("FAIL rr_noack cycle %0d: ack=%b, required 0000", k, ack);
        end
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (valid_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: valid=%b busy=%b, required 0/0", valid_out, busy);
    end
  endtask

  // Continues from round-robin: last grant was 0, so the pointer is 1.
  task automatic test_pointer_skip();
    req = 4'b1001;
    tick();
    checks++;
    if (ack !== 4'b1000 || grant_id !== 2'd3 || Data_out !== 32'h33333333) begin
      errors++;
      $display("FAIL skip_first: ack=%b grant=%0d data=%h, required 1000/3/33333333", ack, grant_id, Data_out);
    end
    tick(); tick(); tick();
    tick();
    checks++;
    if (ack !== 4'b0001 || grant_id !== 2'd0 || valid_out !== 1'b1 || Data_out !== 32'h0) begin
      errors++;
      $display("FAIL skip_second: ack=%b grant=%0d valid=%b data=%h, required 0001/0/1/00000000",
               ack, grant_id, valid_out, Data_out);
    end
    req = 4'b0000;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_noise();
    pulse_reset();
    data_0 = 32'h11111111;
    req = 4'b0001;
    tick();
    checks++;
    if (ack !== 4'b0001 || Data_out !== 32'h11111111) begin
      errors++;
      $display("FAIL noise_start: ack=%b data=%h, required 0001/11111111", ack, Data_out);
    end
    data_0 = 32'h22222222;
    req = 4'b0000;
    tick();
    req = 4'b0001;
    checks++;
    if (ack !== 4'b0000 || Data_out !== 32'h11111111) begin
      errors++;
      $display("FAIL noise_beat1: ack=%b data=%h, required 0000/11111111", ack, Data_out);
    end
    tick();
    req = 4'b0000;
    checks++;
    if (ack !== 4'b0000 || Data_out !== 32'h11111111) begin
      errors++;
      $display("FAIL noise_beat2: ack=%b data=%h, required 0000/11111111", ack, Data_out);
    end
    tick();
    tick();
    checks++;
    if (valid_out !== 1'b0 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL noise_idle: valid=%b ack=%b, required 0/0000", valid_out, ack);
    end
    // Pointer is 1 after granting 0; the dropped request left it alone.
    req = 4'b0011;
    data_1 = 32'h5A5A5A5A;
    tick();
    checks++;
    if (ack !== 4'b0010 || grant_id !== 2'd1 || Data_out !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL noise_ptr: ack=%b grant=%0d data=%h, required 0010/1/5a5a5a5a", ack, grant_id, Data_out);
    end
    req = 4'b0000;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    data_1 = 32'hDEADBEEF;
    data_2 = 32'h0BADCAFE;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick(); tick();
    checks++;
    if (valid_out !== 1'b1 || Data_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL midrst_pre: valid=%b data=%h, required 1/deadbeef", valid_out, Data_out);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || Data_out !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: valid=%b data=%h busy=%b, required 0/0/0", valid_out, Data_out, busy);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b0 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_noresend: valid=%b ack=%b, required 0/0000", valid_out, ack);
    end
    req = 4'b0100;
    tick();
    checks++;
    if (ack !== 4'b0100 || grant_id !== 2'd2 || Data_out !== 32'h0BADCAFE) begin
      errors++;
      $display("FAIL midrst_grant: ack=%b grant=%0d data=%h, required 0100/2/0badcafe", ack, grant_id, Data_out);
    end
    req = 4'b0000;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_gap();
    logic       exp_v;
    logic [3:0] exp_a;
    pulse_reset();
    data_1 = 32'hCAFEF00D;
    req = 4'b0010;
    for (int k = 0; k < 18; k++) begin
      tick();
      exp_v = (k % 6) < 4;
      exp_a = (k % 6 == 0) ? 4'b0010 : 4'b0000;
      checks++;
      if (valid_g !== exp_v || ack_g !== exp_a || data_g !== (exp_v ? 32'hCAFEF00D : 32'h0)) begin
        errors++;
        $display("FAIL gap2 cycle %0d: valid=%b ack=%b data=%h, required %b/%b/%h",
                 k, valid_g, ack_g, data_g, exp_v, exp_a, exp_v ? 32'hCAFEF00D : 32'h0);
      end
    end
    req = 4'b0000;
    tick(); tick(); tick(); tick(); tick(); tick();
    checks++;
    if (valid_g !== 1'b0 || busy_g !== 1'b0) begin
      errors++;
      $display("FAIL gap2_idle: valid=%b busy=%b, required 0/0", valid_g, busy_g);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_skip();
    test_noise();
    test_reset_mid();
    test_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
